// File: rtl/grain_pkg.sv
// Shared types and widths for the Grain keystream controller.
package grain_pkg;

    localparam int unsigned KEY_W      = 80;
    localparam int unsigned IV_W       = 24;
    localparam int unsigned GRAIN_IN_W = 104;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned INIT_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        INIT = 2'd2,
        RUN  = 2'd3
    } state_e;

endpackage

// File: rtl/grain_byte_fifo.sv
// Small byte FIFO for keystream output.
// Ports: clk, rst_n (async active-low), flush (sync clear), push/push_data,
//        pop, head_data (head entry), full, empty (registered flags).
// A push while full is accepted only when a pop happens in the same cycle.
module grain_byte_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              wr_en;
    logic              rd_en;

    // Pop frees a slot first, so push+pop while full is honoured.
    always_comb begin
        rd_en     = pop && !empty && !flush;
        wr_en     = push && !flush && (!full || rd_en);
        count_nxt = count + CW'(wr_en) - CW'(rd_en);
    end

    // Storage, pointers and occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/grain_keystream_ctrl.sv
// Grain control and output stage: loads key/IV into Grain, discards the
// initialization rounds, packs f into LSB-first bytes and queues them.
// Ports: Clk, rst (async active-low), start/stop pulses, key/iv,
//        grain_load/grain_par_in to Grain, grain_f from Grain,
//        ks_data/ks_valid/ks_ready output handshake, busy, init_done,
//        overflow (sticky dropped-byte flag).
module grain_keystream_ctrl
    import grain_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 160,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [KEY_W-1:0]      key,
    input  logic [IV_W-1:0]       iv,
    output logic                  grain_load,
    output logic [GRAIN_IN_W-1:0] grain_par_in,
    input  logic                  grain_f,
    output logic [BYTE_W-1:0]     ks_data,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  busy,
    output logic                  init_done,
    output logic                  overflow
);

    state_e                state;
    logic [KEY_W-1:0]      key_reg;
    logic [IV_W-1:0]       iv_reg;
    logic [INIT_CNT_W-1:0] init_cnt;
    logic [2:0]            bit_cnt;
    logic [6:0]            shreg;

    logic                  start_ok;
    logic                  stop_ok;
    logic                  sample;
    logic                  push;
    logic                  pop;
    logic [BYTE_W-1:0]     byte_c;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Handshake qualifiers; start beats stop in RUN.
    always_comb begin
        start_ok = start && ((state == IDLE) || (state == RUN));
        stop_ok  = stop && (state == RUN) && !start;
        sample   = (state == RUN) && !start && !stop;
        push     = sample && (bit_cnt == 3'd7);
        byte_c   = {grain_f, shreg};
        pop      = ks_valid && ks_ready;
    end

    // Control FSM with counters, byte shifter and sticky overflow.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            key_reg    <= '0;
            iv_reg     <= '0;
            init_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            grain_load <= 1'b0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            grain_load <= 1'b0;

            if (start_ok) begin
                overflow <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg    <= key;
                        iv_reg     <= iv;
                        bit_cnt    <= '0;
                        grain_load <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    init_cnt <= '0;
                    state    <= INIT;
                end
                INIT: begin
                    if (init_cnt == INIT_CNT_W'(INIT_CYCLES - 1)) begin
                        init_cnt  <= '0;
                        init_done <= 1'b1;
                        state     <= RUN;
                    end else begin
                        init_cnt <= init_cnt + INIT_CNT_W'(1);
                    end
                end
                RUN: begin
                    if (start_ok) begin
                        key_reg    <= key;
                        iv_reg     <= iv;
                        bit_cnt    <= '0;
                        grain_load <= 1'b1;
                        init_done  <= 1'b0;
                        state      <= LOAD;
                    end else if (stop_ok) begin
                        bit_cnt   <= '0;
                        busy      <= 1'b0;
                        init_done <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        // Shift right so the first bit lands in byte bit 0.
                        shreg   <= {grain_f, shreg[6:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grain_par_in = {iv_reg, key_reg};
    assign ks_valid     = !fifo_empty;

    grain_byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (BYTE_W)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (rst),
        .flush     (start_ok),
        .push      (push),
        .push_data (byte_c),
        .pop       (pop),
        .head_data (ks_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_grain_keystream_ctrl.sv
module tb_grain_keystream_ctrl;

    localparam int IC    = 160;
    localparam int DEPTH = 4;

    logic         Clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [79:0]  key = '0;
    logic [23:0]  iv = '0;
    logic         grain_load;
    logic [103:0] grain_par_in;
    logic         grain_f = 1'b0;
    logic [7:0]   ks_data;
    logic         ks_valid;
    logic         ks_ready = 1'b0;
    logic         busy;
    logic         init_done;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: time since accepted start plus a byte queue.
    bit          m_active;
    int          m_n;
    logic [7:0]  m_bits;
    logic [7:0]  m_q[$];
    bit          m_ovf;
    logic [79:0] m_key;
    logic [23:0] m_iv;

    grain_keystream_ctrl #(.INIT_CYCLES(IC), .DEPTH(DEPTH)) dut (
        .Clk          (Clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .key          (key),
        .iv           (iv),
        .grain_load   (grain_load),
        .grain_par_in (grain_par_in),
        .grain_f      (grain_f),
        .ks_data      (ks_data),
        .ks_valid     (ks_valid),
        .ks_ready     (ks_ready),
        .busy         (busy),
        .init_done    (init_done),
        .overflow     (overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_n      = 0;
        m_bits   = '0;
        m_q.delete();
        m_ovf    = 0;
        m_key    = '0;
        m_iv     = '0;
    endtask

    task automatic model_push(input logic [7:0] b, input bit popped);
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else if (!popped) m_ovf = 1;
    endtask

    // Apply one rising edge with the inputs that were present before it.
    task automatic model_edge(input bit s, input bit p, input bit f, input bit r,
                              input logic [79:0] k, input logic [23:0] v);
        bit in_run;
        bit popped;
        int b;
        in_run = m_active && (m_n >= IC + 1);
        popped = (m_q.size() > 0) && r;
        if (s && (!m_active || in_run)) begin
            m_q.delete();
            m_ovf    = 0;
            m_active = 1;
            m_n      = 0;
            m_key    = k;
            m_iv     = v;
        end else begin
            if (popped) void'(m_q.pop_front());
            if (m_active) begin
                if (in_run && p) begin
                    m_active = 0;
                end else begin
                    if (in_run) begin
                        b = m_n - (IC + 1);
                        m_bits[b % 8] = f;
                        if (b % 8 == 7) model_push(m_bits, popped);
                    end
                    m_n++;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".grain_load"}, 128'(grain_load), 128'(m_active && m_n == 0));
        chk({tag, ".par_in"}, 128'(grain_par_in), 128'({m_iv, m_key}));
        chk({tag, ".busy"}, 128'(busy), 128'(m_active));
        chk({tag, ".init_done"}, 128'(init_done), 128'(m_active && m_n >= IC + 1));
        chk({tag, ".overflow"}, 128'(overflow), 128'(m_ovf));
        chk({tag, ".ks_valid"}, 128'(ks_valid), 128'(m_q.size() > 0));
        if (m_q.size() > 0) chk({tag, ".ks_data"}, 128'(ks_data), 128'(m_q[0]));
    endtask

    task automatic step(input string tag);
        bit s, p, f, r;
        logic [79:0] k;
        logic [23:0] v;
        s = start; p = stop; f = grain_f; r = ks_ready; k = key; v = iv;
        @(posedge Clk);
        if (!rst) model_reset();
        else model_edge(s, p, f, r, k, v);
        #1;
        check_outputs(tag);
    endtask

    // Pulse start with the given key/iv, then count cycles to init_done.
    task automatic start_and_wait(input string tag, input logic [79:0] k, input logic [23:0] v);
        int cyc;
        key = k; iv = v; start = 1'b1;
        step({tag, ".start"});
        start = 1'b0;
        chk({tag, ".load_par"}, 128'(grain_par_in), 128'({v, k}));
        chk({tag, ".load_pulse"}, 128'(grain_load), 128'(1));
        cyc = 0;
        while (cyc < IC + 10) begin
            grain_f = 1'($urandom);
            step({tag, ".init"});
            cyc++;
            if (cyc == 1) chk({tag, ".load_one_cycle"}, 128'(grain_load), 128'(0));
            if (init_done) break;
        end
        chk({tag, ".init_latency"}, 128'(cyc), 128'(IC + 1));
    endtask

    initial begin
        logic [15:0] pat;
        logic [79:0] k0;
        model_reset();

        // Reset held: toggling inputs must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); stop = 1'($urandom); grain_f = 1'($urandom);
            ks_ready = 1'($urandom); key = {$urandom, $urandom, 16'($urandom)};
            iv = 24'($urandom);
            step("rst_hold");
        end
        chk("rst.ks_data", 128'(ks_data), 128'(0));
        start = 0; stop = 0; ks_ready = 1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step("idle");
        chk("idle.busy", 128'(busy), 128'(0));

        // Load timing and init latency.
        k0 = 80'h0123456789ABCDEF0123;
        start_and_wait("load", k0, 24'hA5A5A5);

        // Bit order: two directed bytes, LSB first.
        pat = 16'b0000_1111_0000_1101;
        for (int i = 0; i < 16; i++) begin
            grain_f = pat[i];
            step("bits");
            if (i == 6) chk("bits.no_valid_before_8", 128'(ks_valid), 128'(0));
            if (i == 7) begin
                chk("bits.first_valid", 128'(ks_valid), 128'(1));
                chk("bits.byte0", 128'(ks_data), 128'(8'h0D));
            end
            if (i == 15) chk("bits.byte1", 128'(ks_data), 128'(8'h0F));
        end
        ks_ready = 1;
        grain_f = 0;
        step("bits.drain");

        // Backpressure: fill FIFO and overflow on byte DEPTH+1.
        ks_ready = 0;
        for (int i = 0; i < (DEPTH + 1) * 8; i++) begin
            grain_f = 1'($urandom);
            step("bp");
            if (i == DEPTH * 8 - 1) chk("bp.no_ovf_yet", 128'(overflow), 128'(0));
        end
        chk("bp.ovf", 128'(overflow), 128'(1));
        chk("bp.full_valid", 128'(ks_valid), 128'(1));
        // Ready only on byte-completion cycles: pop and push together.
        for (int i = 0; i < 16; i++) begin
            grain_f = 1'($urandom);
            ks_ready = (((m_n - (IC + 1)) % 8) == 7);
            step("bp.pop_push");
        end

        // Restart mid-RUN with a partial byte and queued data.
        ks_ready = 0;
        for (int i = 0; i < 3; i++) begin grain_f = 1'($urandom); step("partial"); end
        chk("partial.nonempty", 128'(ks_valid), 128'(1));
        stop = 1'b1;
        start_and_wait("restart", {$urandom, $urandom, 16'($urandom)}, 24'($urandom));
        stop = 1'b0;

        // Accumulate some bytes then stop; queue must drain in IDLE.
        for (int i = 0; i < 27; i++) begin grain_f = 1'($urandom); step("prestop"); end
        stop = 1'b1;
        step("stop");
        stop = 1'b0;
        chk("stop.busy", 128'(busy), 128'(0));
        chk("stop.queued", 128'(ks_valid), 128'(1));
        ks_ready = 1;
        for (int i = 0; i < DEPTH + 2; i++) begin grain_f = 1'($urandom); step("drain"); end
        chk("drain.empty", 128'(ks_valid), 128'(0));

        // Randomized operation against the model.
        start_and_wait("rand0", {$urandom, $urandom, 16'($urandom)}, 24'($urandom));
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 299) == 0);
            stop     = ($urandom_range(0, 99) == 0);
            grain_f  = 1'($urandom);
            ks_ready = ($urandom_range(0, 3) != 0);
            key      = {$urandom, $urandom, 16'($urandom)};
            iv       = 24'($urandom);
            step("rand");
        end
        start = 0; stop = 0;

        // Reset asserted mid-INIT at init_cnt=50.
        key = {$urandom, $urandom, 16'($urandom)}; iv = 24'($urandom);
        stop = 1'b0; start = 1'b1;
        step("mid.start");
        start = 1'b0;
        for (int i = 0; i < 200 && !(m_active && m_n == 51); i++) step("mid.init");
        chk("mid.reached", 128'(m_active && m_n == 51), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("mid.async");
        step("mid.held");
        rst = 1'b1;
        step("mid.released");
        start_and_wait("mid.again", {$urandom, $urandom, 16'($urandom)}, 24'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
